// File: rtl/onchip_mem_bist.sv
// Memory BIST master: writes a pattern over a word range, reads it back and checks it.
// Define ONCHIP_MEM_BIST_ERRCNT_EN to add the saturating err_count mismatch counter.
module onchip_mem_bist #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   length,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic              clken,
  input  logic [DATA_W-1:0] readdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
`ifdef ONCHIP_MEM_BIST_ERRCNT_EN
  output logic [ADDR_W:0]   err_count,
`endif
  output logic [ADDR_W-1:0] fail_addr
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned LFSR_W    = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                cs_q, cs_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic                cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0]   cmp_exp_q, cmp_exp_d;
  logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
  logic                pass_q, pass_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   issue_addr;
  logic                mismatch;
`ifdef ONCHIP_MEM_BIST_ERRCNT_EN
  logic [CNT_W-1:0]    errcnt_q, errcnt_d;
`endif

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    lfsr_next = {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : LFSR_W'(0));
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed starts from 1.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [DATA_W-1:0] s);
    logic [LFSR_W-1:0] v;
    v = LFSR_W'(s);
    seed_fix = (v == LFSR_W'(0)) ? LFSR_W'(1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] sd, input logic [LFSR_W-1:0] lf);
    case (m)
      2'b00:   pattern = DATA_W'(a);
      2'b01:   pattern = ~DATA_W'(a);
      2'b10:   pattern = sd;
      default: pattern = DATA_W'(lf);
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    base_d      = base_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    lfsr_d      = lfsr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    exp_d       = exp_q;
    cs_d        = 1'b0;
    we_d        = 1'b0;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    // A read issued last cycle has its data on readdata this cycle.
    cmp_vld_d   = cs_q & ~we_q;
    cmp_exp_d   = exp_q;
    cmp_addr_d  = addr_q;
    issue_addr  = base_q + idx_q[ADDR_W-1:0];
    mismatch    = cmp_vld_q && (readdata != cmp_exp_q);
`ifdef ONCHIP_MEM_BIST_ERRCNT_EN
    errcnt_d    = errcnt_q;
    if (mismatch && (errcnt_q != {CNT_W{1'b1}})) errcnt_d = errcnt_q + CNT_W'(1);
`endif

    if (mismatch && pass_q) begin
      pass_d      = 1'b0;
      fail_addr_d = cmp_addr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d      = base;
          len_d       = length;
          mode_d      = mode;
          seed_d      = seed;
          pass_d      = 1'b1;
          fail_addr_d = '0;
`ifdef ONCHIP_MEM_BIST_ERRCNT_EN
          errcnt_d    = '0;
`endif
          if (length == CNT_W'(0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WR;
            cs_d    = 1'b1;
            we_d    = 1'b1;
            addr_d  = base;
            wdata_d = pattern(mode, base, seed, seed_fix(seed));
            lfsr_d  = lfsr_next(seed_fix(seed));
            idx_d   = CNT_W'(1);
          end
        end
      end
      S_WR: begin
        if (idx_q == len_q) begin
          state_d = S_RD;
          cs_d    = 1'b1;
          addr_d  = base_q;
          exp_d   = pattern(mode_q, base_q, seed_q, seed_fix(seed_q));
          lfsr_d  = lfsr_next(seed_fix(seed_q));
          idx_d   = CNT_W'(1);
        end else begin
          cs_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = issue_addr;
          wdata_d = pattern(mode_q, issue_addr, seed_q, lfsr_q);
          lfsr_d  = lfsr_next(lfsr_q);
          idx_d   = idx_q + CNT_W'(1);
        end
      end
      S_RD: begin
        if (idx_q == len_q) begin
          state_d = S_DRAIN;
        end else begin
          cs_d   = 1'b1;
          addr_d = issue_addr;
          exp_d  = pattern(mode_q, issue_addr, seed_q, lfsr_q);
          lfsr_d = lfsr_next(lfsr_q);
          idx_d  = idx_q + CNT_W'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cs_d      = 1'b0;
      we_d      = 1'b0;
      pass_d    = 1'b0;
      cmp_vld_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      mode_q      <= '0;
      seed_q      <= DATA_W'(1);
      lfsr_q      <= LFSR_W'(1);
      addr_q      <= '0;
      wdata_q     <= '0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      exp_q       <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      pass_q      <= 1'b1;
      fail_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ONCHIP_MEM_BIST_ERRCNT_EN
      errcnt_q    <= '0;
`endif
    end else begin
      idx_q       <= idx_d;
      len_q       <= len_d;
      base_q      <= base_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      lfsr_q      <= lfsr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      exp_q       <= exp_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ONCHIP_MEM_BIST_ERRCNT_EN
      errcnt_q    <= errcnt_d;
`endif
    end
  end

  assign address    = addr_q;
  assign byteenable = 4'hF;
  assign chipselect = cs_q;
  assign write      = we_q;
  assign writedata  = wdata_q;
  assign clken      = 1'b1;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_addr  = fail_addr_q;
`ifdef ONCHIP_MEM_BIST_ERRCNT_EN
  assign err_count  = errcnt_q;
`endif

endmodule

// File: tb/tb_onchip_mem_bist.sv
// Scoreboard bench for onchip_mem_bist: expected bus accesses are queued per test and
// checked as they appear; each test task checks latency, pass and fail_addr inline.
module tb_onchip_mem_bist;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] data;
  } acc_t;

  logic              clk, reset, start, abort;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   length;
  logic [1:0]        mode;
  logic [DATA_W-1:0] seed;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect, write, clken;
  logic [DATA_W-1:0] writedata, readdata;
  logic              busy, done, pass;
  logic [ADDR_W-1:0] fail_addr;
  logic [ADDR_W:0]   err_count;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  bit                corrupt [0:DEPTH-1];
  acc_t              exp_q[$];
  acc_t              mon_e;
  int                checks = 0;
  int                errors = 0;

  onchip_mem_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base(base), .length(length), .mode(mode), .seed(seed),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .writedata(writedata), .clken(clken), .readdata(readdata),
    .busy(busy), .done(done), .pass(pass),
`ifdef ONCHIP_MEM_BIST_ERRCNT_EN
    .err_count(err_count),
`endif
    .fail_addr(fail_addr)
  );

`ifndef ONCHIP_MEM_BIST_ERRCNT_EN
  assign err_count = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory; corrupted words read back with bit 8 flipped.
  always @(posedge clk) begin
    if (chipselect) begin
      if (write) mem[address] <= writedata;
      else       readdata <= mem[address] ^ (corrupt[address] ? 32'h0000_0100 : 32'h0);
    end
  end

  always @(negedge clk) begin
    if (!reset && chipselect) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_access got addr=%h we=%b, required no access", address, write);
      end else begin
        mon_e = exp_q.pop_front();
        if (address !== mon_e.addr || write !== mon_e.we ||
            (mon_e.we && (writedata !== mon_e.data || byteenable !== 4'hF))) begin
          errors++;
          $display("FAIL access got addr=%h we=%b data=%h be=%h required addr=%h we=%b data=%h be=f",
                   address, write, writedata, byteenable, mon_e.addr, mon_e.we, mon_e.data);
        end
      end
    end
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic lsb;
    lsb = s[0];
    s = s >> 1;
    if (lsb) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] model_data(input logic [1:0] m, input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] sd, input logic [31:0] lf);
    if (m == 2'b00)      return {18'h0, a};
    else if (m == 2'b01) return {18'h3FFFF, ~a};
    else if (m == 2'b10) return sd;
    else                 return lf;
  endfunction

  task automatic push_expected(input logic [ADDR_W-1:0] b, input int len, input logic [1:0] m,
                               input logic [DATA_W-1:0] sd);
    logic [31:0] lf;
    acc_t e;
    lf = (sd == 0) ? 32'h1 : sd;
    for (int k = 0; k < len; k++) begin
      e.addr = ADDR_W'(int'(b) + k);
      e.we   = 1'b1;
      e.data = model_data(m, e.addr, sd, lf);
      exp_q.push_back(e);
      lf = lfsr_step(lf);
    end
    for (int k = 0; k < len; k++) begin
      e.addr = ADDR_W'(int'(b) + k);
      e.we   = 1'b0;
      e.data = '0;
      exp_q.push_back(e);
    end
  endtask

  // Queues the expected accesses, pulses start and waits (bounded) for done.
  task automatic run_test(input logic [ADDR_W-1:0] b, input int len, input logic [1:0] m,
                          input logic [DATA_W-1:0] sd, input logic ab,
                          output int cycles, output logic ps, output logic [ADDR_W-1:0] fa,
                          output logic [ADDR_W:0] ec, output logic after);
    push_expected(b, len, m, sd);
    @(negedge clk);
    base = b; length = (ADDR_W+1)'(len); mode = m; seed = sd; start = 1'b1; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < 2 * len + 20) begin
      @(negedge clk);
      cycles++;
    end
    if (done !== 1'b1) cycles = -1;
    ps = pass; fa = fail_addr; ec = err_count;
    @(negedge clk);
    after = done | busy;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_status got busy=%b done=%b required 0 0", busy, done); end
    checks++; if (chipselect !== 1'b0 || write !== 1'b0) begin errors++; $display("FAIL reset_bus got cs=%b we=%b required 0 0", chipselect, write); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL reset_pass got %b required 1", pass); end
    checks++; if (fail_addr !== '0 || address !== '0 || writedata !== '0) begin errors++; $display("FAIL reset_regs got fa=%h addr=%h wd=%h required 0", fail_addr, address, writedata); end
    checks++; if (clken !== 1'b1) begin errors++; $display("FAIL clken got %b required 1", clken); end
    reset = 1'b0;
  endtask

  task automatic test_addr_mode();
    int cyc; logic ps, af; logic [ADDR_W-1:0] fa; logic [ADDR_W:0] ec;
    run_test(14'h0000, 16, 2'b00, 32'h0, 1'b0, cyc, ps, fa, ec, af);
    checks++; if (cyc != 34) begin errors++; $display("FAIL addr_latency got %0d required 34", cyc); end
    checks++; if (ps !== 1'b1) begin errors++; $display("FAIL addr_pass got %b required 1", ps); end
    checks++; if (af !== 1'b0) begin errors++; $display("FAIL addr_done_width got done|busy=%b required 0", af); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL addr_pass_hold got %b required 1", pass); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL addr_missing got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_wrap_inverse();
    int cyc; logic ps, af; logic [ADDR_W-1:0] fa; logic [ADDR_W:0] ec;
    run_test(14'h3FFE, 4, 2'b01, 32'h0, 1'b0, cyc, ps, fa, ec, af);
    checks++; if (cyc != 10 || ps !== 1'b1) begin errors++; $display("FAIL wrap got cyc=%0d pass=%b required 10 1", cyc, ps); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_missing got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_lfsr_corrupt();
    int cyc; logic ps, af; logic [ADDR_W-1:0] fa; logic [ADDR_W:0] ec;
    corrupt[14'h105] = 1'b1; corrupt[14'h107] = 1'b1;
    run_test(14'h0100, 8, 2'b11, 32'h0, 1'b0, cyc, ps, fa, ec, af);
    corrupt[14'h105] = 1'b0; corrupt[14'h107] = 1'b0;
    checks++; if (cyc != 18) begin errors++; $display("FAIL lfsr_latency got %0d required 18", cyc); end
    checks++; if (ps !== 1'b0 || fa !== 14'h105) begin errors++; $display("FAIL lfsr_fail got pass=%b fa=%h required 0 105", ps, fa); end
`ifdef ONCHIP_MEM_BIST_ERRCNT_EN
    checks++; if (ec !== 15'd2) begin errors++; $display("FAIL lfsr_errcnt got %0d required 2", ec); end
`endif
    checks++; if (pass !== 1'b0 || fail_addr !== 14'h105) begin errors++; $display("FAIL lfsr_hold got pass=%b fa=%h required 0 105", pass, fail_addr); end
  endtask

  task automatic test_zero_length();
    int cyc; logic ps, af; logic [ADDR_W-1:0] fa; logic [ADDR_W:0] ec;
    run_test(14'h0200, 0, 2'b00, 32'h0, 1'b0, cyc, ps, fa, ec, af);
    checks++; if (cyc != 1) begin errors++; $display("FAIL zero_latency got %0d required 1", cyc); end
    checks++; if (ps !== 1'b1 || af !== 1'b0) begin errors++; $display("FAIL zero_result got pass=%b after=%b required 1 0", ps, af); end
  endtask

  task automatic test_seed_first_word();
    int cyc; logic ps, af; logic [ADDR_W-1:0] fa; logic [ADDR_W:0] ec;
    corrupt[14'h3FFF] = 1'b1;
    run_test(14'h3FFF, 3, 2'b10, 32'hA5A5_5A5A, 1'b0, cyc, ps, fa, ec, af);
    corrupt[14'h3FFF] = 1'b0;
    checks++; if (cyc != 8 || ps !== 1'b0 || fa !== 14'h3FFF) begin errors++; $display("FAIL seed got cyc=%0d pass=%b fa=%h required 8 0 3fff", cyc, ps, fa); end
`ifdef ONCHIP_MEM_BIST_ERRCNT_EN
    checks++; if (ec !== 15'd1) begin errors++; $display("FAIL seed_errcnt got %0d required 1", ec); end
`endif
  endtask

  task automatic test_abort();
    int n; bit saw_done;
    push_expected(14'h0020, 8, 2'b00, 32'h0);
    @(negedge clk);
    base = 14'h0020; length = 15'd8; mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 0;
    while (!(chipselect === 1'b1 && write === 1'b0 && address === 14'h0023) && n < 100) begin
      @(negedge clk); n++;
    end
    checks++; if (n >= 100) begin errors++; $display("FAIL abort_reach got timeout required read 0023"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_q.delete();
    checks++; if (busy !== 1'b0 || chipselect !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL abort_state got busy=%b cs=%b pass=%b required 0 0 0", busy, chipselect, pass); end
    saw_done = 0;
    repeat (30) begin @(negedge clk); if (done === 1'b1) saw_done = 1; end
    checks++; if (saw_done || pass !== 1'b0) begin errors++; $display("FAIL abort_done got done_seen=%b pass=%b required 0 0", saw_done, pass); end
  endtask

  task automatic test_abort_with_start();
    int cyc; logic ps, af; logic [ADDR_W-1:0] fa; logic [ADDR_W:0] ec;
    run_test(14'h0300, 2, 2'b01, 32'h0, 1'b1, cyc, ps, fa, ec, af);
    checks++; if (cyc != 6 || ps !== 1'b1) begin errors++; $display("FAIL abort_start got cyc=%0d pass=%b required 6 1", cyc, ps); end
  endtask

  task automatic test_busy_start();
    int n;
    push_expected(14'h0080, 6, 2'b00, 32'h0);
    @(negedge clk);
    base = 14'h0080; length = 15'd6; mode = 2'b00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    base = 14'h0200; length = 15'd3; mode = 2'b01; start = 1'b1;
    @(negedge clk); start = 1'b0; n = 4;
    while (done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++; if (n != 14 || pass !== 1'b1) begin errors++; $display("FAIL busy_start got cyc=%0d pass=%b required 14 1", n, pass); end
    @(negedge clk);
    checks++; if (exp_q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL busy_start_end got left=%0d busy=%b required 0 0", exp_q.size(), busy); end
  endtask

  task automatic test_reset_mid_wr();
    int n, cyc; logic ps, af; logic [ADDR_W-1:0] fa; logic [ADDR_W:0] ec;
    push_expected(14'h0040, 8, 2'b10, 32'h1234_5678);
    @(negedge clk);
    base = 14'h0040; length = 15'd8; mode = 2'b10; seed = 32'h1234_5678; start = 1'b1;
    @(negedge clk); start = 1'b0; n = 0;
    while (!(chipselect === 1'b1 && address === 14'h0042) && n < 50) begin @(negedge clk); n++; end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || chipselect !== 1'b0 || write !== 1'b0) begin errors++; $display("FAIL rst_mid_status got busy=%b done=%b cs=%b we=%b required 0", busy, done, chipselect, write); end
    checks++; if (address !== '0 || writedata !== '0 || pass !== 1'b1 || fail_addr !== '0) begin errors++; $display("FAIL rst_mid_regs got addr=%h wd=%h pass=%b fa=%h required 0 0 1 0", address, writedata, pass, fail_addr); end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    run_test(14'h0050, 3, 2'b11, 32'hDEAD_BEEF, 1'b0, cyc, ps, fa, ec, af);
    checks++; if (cyc != 8 || ps !== 1'b1) begin errors++; $display("FAIL rst_rerun got cyc=%0d pass=%b required 8 1", cyc, ps); end
  endtask

  task automatic test_full_length();
    int cyc; logic ps, af; logic [ADDR_W-1:0] fa; logic [ADDR_W:0] ec;
    run_test(14'h1234, DEPTH, 2'b01, 32'h0, 1'b0, cyc, ps, fa, ec, af);
    checks++; if (cyc != 2 * DEPTH + 2 || ps !== 1'b1) begin errors++; $display("FAIL full got cyc=%0d pass=%b required %0d 1", cyc, ps, 2 * DEPTH + 2); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_missing got %0d left required 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    base = '0; length = '0; mode = '0; seed = '0;
    for (int i = 0; i < DEPTH; i++) corrupt[i] = 1'b0;
    test_reset();
    test_addr_mode();
    test_wrap_inverse();
    test_lfsr_corrupt();
    test_zero_length();
    test_seed_first_word();
    test_abort();
    test_abort_with_start();
    test_busy_start();
    test_reset_mid_wr();
    test_full_length();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
